// File: rtl/avf_pkg.sv
// ---------------------------------------------------------------------------
// avf_pkg
// Definitions shared by the AVF window monitor and its accumulator.
//   avf_win_state_t   : window FSM state (IDLE / RUN / HOLD)
//   AVF_ACC_W_DEFAULT : default accumulator / threshold width
//   avf_eff_len()     : maps a requested window length of 0 to 1
// ---------------------------------------------------------------------------
package avf_pkg;

    localparam int AVF_ACC_W_DEFAULT = 19;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } avf_win_state_t;

    // A zero-length window would never terminate, so it is run as one cycle.
    function automatic logic [15:0] avf_eff_len(input logic [15:0] len);
        return (len == 16'd0) ? 16'd1 : len;
    endfunction

endpackage

// File: rtl/avf_accum.sv
// ---------------------------------------------------------------------------
// avf_accum
// ACE bit-count accumulator for one measurement window.
// Configuration macro: AVF_ACC_SAT_EN
//   defined   -> the sum saturates at all-ones and stays there
//   undefined -> the sum wraps modulo 2^ACC_W
// Ports:
//   clk      in   clock, rising edge
//   reset    in   synchronous active-high reset
//   clr      in   clear the accumulator (has priority over en)
//   en       in   add inc this cycle
//   inc      in   3-bit increment, zero-extended
//   sum_nxt  out  accumulator value including this cycle's inc
// ---------------------------------------------------------------------------
module avf_accum
    import avf_pkg::*;
#(
    parameter int ACC_W = AVF_ACC_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [2:0]       inc,
    output logic [ACC_W-1:0] sum_nxt
);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W:0]   sum_wide;

    always_comb begin
        // One extra bit captures the carry out for saturation detection.
        sum_wide = {1'b0, acc_q} + {{(ACC_W-2){1'b0}}, inc};
`ifdef AVF_ACC_SAT_EN
        sum_nxt = sum_wide[ACC_W] ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
`else
        sum_nxt = sum_wide[ACC_W-1:0];
`endif
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = sum_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/avf_window_monitor.sv
// ---------------------------------------------------------------------------
// avf_window_monitor
// Sums per-cycle ACE bit counts over a window of N cycles and flags the
// window when the sum exceeds a threshold. The result is held with a
// valid/ready handshake.
// Configuration macro: AVF_ACC_SAT_EN (saturating accumulator, see avf_accum)
// Ports:
//   clk         in   clock, rising edge
//   reset       in   synchronous active-high reset
//   start       in   begin a window (honoured in IDLE only)
//   window_len  in   window length in cycles, 0 treated as 1
//   threshold   in   ACE-sum limit
//   ace_inc     in   per-cycle ACE increment 0..7
//   busy        out  high in RUN and HOLD
//   res_valid   out  result presented
//   res_ready   in   consumer accepts result
//   ace_sum     out  accumulated ACE count of the last window
//   avf_high    out  ace_sum > latched threshold
// ---------------------------------------------------------------------------
module avf_window_monitor
    import avf_pkg::*;
#(
    parameter int ACC_W = AVF_ACC_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [15:0]      window_len,
    input  logic [ACC_W-1:0] threshold,
    input  logic [2:0]       ace_inc,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ACC_W-1:0] ace_sum,
    output logic             avf_high
);

    avf_win_state_t   state_q, state_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [15:0]      len_q, len_d;
    logic [ACC_W-1:0] thr_q, thr_d;
    logic [ACC_W-1:0] ace_sum_q, ace_sum_d;
    logic             avf_high_q, avf_high_d;
    logic             res_valid_q, res_valid_d;
    logic             busy_q, busy_d;
    logic             acc_clr, acc_en;
    logic [ACC_W-1:0] acc_sum_nxt;

    avf_accum #(.ACC_W(ACC_W)) u_accum (
        .clk     (clk),
        .reset   (reset),
        .clr     (acc_clr),
        .en      (acc_en),
        .inc     (ace_inc),
        .sum_nxt (acc_sum_nxt)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        thr_d       = thr_q;
        ace_sum_d   = ace_sum_q;
        avf_high_d  = avf_high_q;
        res_valid_d = res_valid_q;
        busy_d      = busy_q;
        acc_clr     = 1'b0;
        acc_en      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    len_d   = avf_eff_len(window_len);
                    thr_d   = threshold;
                    cnt_d   = 16'd0;
                    acc_clr = 1'b1;
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                acc_en = 1'b1;
                cnt_d  = cnt_q + 16'd1;
                // Last sampled cycle: publish the sum including this cycle's inc.
                if (cnt_q == len_q - 16'd1) begin
                    ace_sum_d   = acc_sum_nxt;
                    avf_high_d  = (acc_sum_nxt > thr_q);
                    res_valid_d = 1'b1;
                    state_d     = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                res_valid_d = 1'b0;
                busy_d      = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            len_q       <= '0;
            thr_q       <= '0;
            ace_sum_q   <= '0;
            avf_high_q  <= 1'b0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            thr_q       <= thr_d;
            ace_sum_q   <= ace_sum_d;
            avf_high_q  <= avf_high_d;
            res_valid_q <= res_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign busy      = busy_q;
    assign res_valid = res_valid_q;
    assign ace_sum   = ace_sum_q;
    assign avf_high  = avf_high_q;

endmodule
